// File: rtl/seq_det_pkg.sv
// Shared types and constants for the seq_det serial link receiver.
// SEQ_DET_PARITY_EN selects the even-parity frame format (PAR state reachable).
package seq_det_pkg;

  localparam int DEF_DATA_W = 10;

  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    STOP  = 2'd3
  } state_t;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_DATA_W);

endpackage

// File: rtl/seq_det_sipo.sv
// Serial-in parallel-out shifter with bit counter and running even parity.
// SEQ_DET_PARITY_EN adds the running parity flop and its output port.
module seq_det_sipo
  import seq_det_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_shift_en,
  input  logic              i_din,
  output logic [DATA_W-1:0] o_sreg,
  output logic              o_done
`ifdef SEQ_DET_PARITY_EN
  ,
  output logic              o_par
`endif
);

  localparam int CNT_W = cnt_width(DATA_W);

  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;

  always_comb begin
    sreg_d    = sreg_q;
    bit_cnt_d = bit_cnt_q;
    if (i_clear) begin
      bit_cnt_d = '0;
    end else if (i_shift_en) begin
      sreg_d    = {sreg_q[DATA_W-2:0], i_din};
      bit_cnt_d = bit_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sreg_q    <= '0;
      bit_cnt_q <= '0;
    end else begin
      sreg_q    <= sreg_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // High while the last data bit is on the line, so the FSM leaves SHIFT on that edge.
  assign o_done = (bit_cnt_q == CNT_W'(DATA_W - 1));
  assign o_sreg = sreg_q;

`ifdef SEQ_DET_PARITY_EN
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (i_clear) begin
      par_d = 1'b0;
    end else if (i_shift_en) begin
      par_d = par_q ^ i_din;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign o_par = par_q;
`endif

endmodule

// File: rtl/seq_det_rx.sv
// Receive end of the seq_det link: framing, optional parity and count-continuity checks.
// SEQ_DET_PARITY_EN enables the parity bit between data and stop.
//   state | meaning
//   IDLE  | waiting for a start bit while i_rx_en is high
//   SHIFT | shifting DATA_W data bits, MSB first
//   PAR   | sampling the even-parity bit (parity build only)
//   STOP  | sampling the stop bit and registering the frame outcome
module seq_det_rx
  import seq_det_pkg::*;
#(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter logic [DATA_W-1:0] MATCH_VAL = 10'h3FF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rx_en,
  input  logic              i_serial_data,
  output logic [DATA_W-1:0] o_count,
  output logic              o_count_valid,
  output logic              o_match,
  output logic              o_seq_err,
  output logic              o_frame_err,
  output logic              o_parity_err,
  output logic              o_busy
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic [DATA_W-1:0] expected_q, expected_d;
  logic              first_seen_q, first_seen_d;
  logic              valid_q, valid_d;
  logic              match_q, match_d;
  logic              seq_err_q, seq_err_d;
  logic              frame_err_q, frame_err_d;

  logic              sipo_clear, sipo_shift, sipo_done;
  logic [DATA_W-1:0] sipo_sreg;

`ifdef SEQ_DET_PARITY_EN
  logic sipo_par;
  logic par_bad_q, par_bad_d;
  logic parity_err_q, parity_err_d;
`endif

  seq_det_sipo #(.DATA_W(DATA_W)) u_sipo (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    (sipo_clear),
    .i_shift_en (sipo_shift),
    .i_din      (i_serial_data),
    .o_sreg     (sipo_sreg),
    .o_done     (sipo_done)
`ifdef SEQ_DET_PARITY_EN
    ,
    .o_par      (sipo_par)
`endif
  );

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    expected_d   = expected_q;
    first_seen_d = first_seen_q;
    valid_d      = 1'b0;
    match_d      = 1'b0;
    seq_err_d    = 1'b0;
    frame_err_d  = 1'b0;
    sipo_clear   = 1'b0;
    sipo_shift   = 1'b0;
`ifdef SEQ_DET_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (i_rx_en && (i_serial_data == START_BIT)) begin
          state_d    = SHIFT;
          sipo_clear = 1'b1;
        end
      end
      SHIFT: begin
        sipo_shift = 1'b1;
        if (sipo_done) begin
`ifdef SEQ_DET_PARITY_EN
          state_d = PAR;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef SEQ_DET_PARITY_EN
      PAR: begin
        par_bad_d = sipo_par ^ i_serial_data;
        state_d   = STOP;
      end
`endif
      STOP: begin
        state_d = IDLE;
        if (i_serial_data != STOP_BIT) begin
          frame_err_d = 1'b1;
`ifdef SEQ_DET_PARITY_EN
        end else if (par_bad_q) begin
          parity_err_d = 1'b1;
`endif
        end else begin
          // Continuity is only judged once a first good word has seeded expected.
          count_d      = sipo_sreg;
          valid_d      = 1'b1;
          match_d      = (sipo_sreg == MATCH_VAL);
          seq_err_d    = first_seen_q && (sipo_sreg != expected_q);
          expected_d   = sipo_sreg + 1'b1;
          first_seen_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      expected_q   <= '0;
      first_seen_q <= 1'b0;
      valid_q      <= 1'b0;
      match_q      <= 1'b0;
      seq_err_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      expected_q   <= expected_d;
      first_seen_q <= first_seen_d;
      valid_q      <= valid_d;
      match_q      <= match_d;
      seq_err_q    <= seq_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

`ifdef SEQ_DET_PARITY_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign o_parity_err = parity_err_q;
`else
  assign o_parity_err = 1'b0;
`endif

  assign o_count       = count_q;
  assign o_count_valid = valid_q;
  assign o_match       = match_q;
  assign o_seq_err     = seq_err_q;
  assign o_frame_err   = frame_err_q;
  assign o_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_seq_det_rx.sv
// Directed self-checking bench for seq_det_rx; honours SEQ_DET_PARITY_EN when defined.
module tb_seq_det_rx;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_rx_en;
  logic       i_serial_data;
  logic [9:0] o_count;
  logic       o_count_valid;
  logic       o_match;
  logic       o_seq_err;
  logic       o_frame_err;
  logic       o_parity_err;
  logic       o_busy;

  int n_assert = 0;
  int n_fail   = 0;

  seq_det_rx dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_rx_en       (i_rx_en),
    .i_serial_data (i_serial_data),
    .o_count       (o_count),
    .o_count_valid (o_count_valid),
    .o_match       (o_match),
    .o_seq_err     (o_seq_err),
    .o_frame_err   (o_frame_err),
    .o_parity_err  (o_parity_err),
    .o_busy        (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    @(negedge i_clk);
    i_serial_data = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b0);
  endtask

  // Returns right after the stop bit has been driven; the next negedge is the next bit slot.
  task automatic send_frame(input logic [9:0] d, input logic stop_b,
                            input logic par_flip, input logic drop_en);
    drive_bit(1'b1);
    for (int i = 9; i >= 0; i--) begin
      drive_bit(d[i]);
      if (drop_en) i_rx_en = 1'b0;
    end
`ifdef SEQ_DET_PARITY_EN
    drive_bit((^d) ^ par_flip);
`else
    if (par_flip) $display("note: parity flip has no effect without parity build");
`endif
    drive_bit(stop_b);
  endtask

  task automatic check_outcome(input string tag, input logic v, input logic [9:0] c,
                               input logic m, input logic s, input logic f, input logic p);
    @(posedge i_clk);
    #1;
    chk({tag, "_valid"}, {31'd0, o_count_valid}, {31'd0, v});
    chk({tag, "_count"}, {22'd0, o_count}, {22'd0, c});
    chk({tag, "_match"}, {31'd0, o_match}, {31'd0, m});
    chk({tag, "_seq_err"}, {31'd0, o_seq_err}, {31'd0, s});
    chk({tag, "_frame_err"}, {31'd0, o_frame_err}, {31'd0, f});
    chk({tag, "_parity_err"}, {31'd0, o_parity_err}, {31'd0, p});
  endtask

  initial begin
    i_rst_n       = 1'b0;
    i_rx_en       = 1'b1;
    i_serial_data = 1'b0;
    repeat (2) @(negedge i_clk);
    chk("rst_count", {22'd0, o_count}, 32'h0);
    chk("rst_valid", {31'd0, o_count_valid}, 32'h0);
    chk("rst_busy", {31'd0, o_busy}, 32'h0);
    chk("rst_frame_err", {31'd0, o_frame_err}, 32'h0);
    i_rst_n = 1'b1;
    idle(2);

    // Back-to-back first words
    send_frame(10'h005, 1'b0, 1'b0, 1'b0);
    check_outcome("w005", 1'b1, 10'h005, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(10'h006, 1'b0, 1'b0, 1'b0);
    check_outcome("w006", 1'b1, 10'h006, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge i_clk);
    #1;
    chk("w006_pulse_end", {31'd0, o_count_valid}, 32'h0);
    chk("w006_busy_end", {31'd0, o_busy}, 32'h0);

    // Jump to 3FE, then wrap through match value
    send_frame(10'h3FE, 1'b0, 1'b0, 1'b0);
    check_outcome("w3fe", 1'b1, 10'h3FE, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(10'h3FF, 1'b0, 1'b0, 1'b0);
    check_outcome("w3ff", 1'b1, 10'h3FF, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(10'h000, 1'b0, 1'b0, 1'b0);
    check_outcome("w000", 1'b1, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Sequence errors and resync
    send_frame(10'h010, 1'b0, 1'b0, 1'b0);
    check_outcome("w010", 1'b1, 10'h010, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(10'h012, 1'b0, 1'b0, 1'b0);
    check_outcome("w012", 1'b1, 10'h012, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(10'h013, 1'b0, 1'b0, 1'b0);
    check_outcome("w013", 1'b1, 10'h013, 1'b0, 1'b0, 1'b0, 1'b0);

    // Framing error does not disturb count or expected
    send_frame(10'h020, 1'b0, 1'b0, 1'b0);
    check_outcome("w020", 1'b1, 10'h020, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(10'h020, 1'b1, 1'b0, 1'b0);
    check_outcome("w020_bad_stop", 1'b0, 10'h020, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    send_frame(10'h021, 1'b0, 1'b0, 1'b0);
    check_outcome("w021", 1'b1, 10'h021, 1'b0, 1'b0, 1'b0, 1'b0);

    // Receiver disabled: start bit ignored
    i_rx_en = 1'b0;
    drive_bit(1'b1);
    @(posedge i_clk);
    #1;
    chk("dis_busy", {31'd0, o_busy}, 32'h0);
    for (int i = 9; i >= 0; i--) drive_bit(i[0]);
    drive_bit(1'b0);
    check_outcome("dis", 1'b0, 10'h021, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("dis_busy_end", {31'd0, o_busy}, 32'h0);
    @(negedge i_clk);
    i_rx_en = 1'b1;

    // Reset in the middle of SHIFT
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    @(posedge i_clk);
    #1;
    chk("mid_busy", {31'd0, o_busy}, 32'h1);
    @(negedge i_clk);
    i_rst_n       = 1'b0;
    i_serial_data = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, o_busy}, 32'h0);
    chk("mid_rst_count", {22'd0, o_count}, 32'h0);
    chk("mid_rst_valid", {31'd0, o_count_valid}, 32'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    idle(1);
    send_frame(10'h001, 1'b0, 1'b0, 1'b0);
    check_outcome("w001", 1'b1, 10'h001, 1'b0, 1'b0, 1'b0, 1'b0);

    // rx_en dropped mid-frame still completes
    send_frame(10'h002, 1'b0, 1'b0, 1'b1);
    check_outcome("w002_drop", 1'b1, 10'h002, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge i_clk);
    i_serial_data = 1'b0;
    i_rx_en       = 1'b1;

`ifdef SEQ_DET_PARITY_EN
    send_frame(10'h003, 1'b0, 1'b1, 1'b0);
    check_outcome("w003_bad_par", 1'b0, 10'h002, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(10'h003, 1'b0, 1'b0, 1'b0);
    check_outcome("w003", 1'b1, 10'h003, 1'b0, 1'b0, 1'b0, 1'b0);
`else
    send_frame(10'h003, 1'b0, 1'b0, 1'b0);
    check_outcome("w003", 1'b1, 10'h003, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
